csr_neighbor_fetcher: RTL and testbench
=======================================

Name: csr_neighbor_fetcher

Overview:
Requester-side engine for the CSR graph store. It accepts a vertex id and reads the row pointers `rowidx[v]` and `rowidx[v+1]` from the single-port index memory. It then reads every edge entry `data[rowidx[v] .. rowidx[v+1]-1]` through the two data read ports, alternating A and B. Neighbour ids stream out in ascending address order under valid/ready, buffered in an internal FIFO, so that downstream traversal logic (BFS/frontier processors) never touches the memory handshake.

Parameters:
- PROC_BITS, 4, width of the processor-id field carried in the upper bits of every memory address.
- PROC_ID, 0, value driven into address bits [31+PROC_BITS:32].
- OUT_DEPTH, 8, output FIFO depth in entries; power of 2, minimum 4.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset
- req_vertex  in  32  vertex id to expand
- req_valid  in  1  request strobe; accepted when req_valid && req_ready
- req_ready  out  1  high only in IDLE
- nbr_out  out  32  neighbour id (FIFO head)
- nbr_valid  out  1  FIFO non-empty
- nbr_ready  in  1  consumer accepts the head this cycle
- nbr_last  out  1  head is the final neighbour of the current vertex
- done_out  out  1  one-cycle pulse when the expansion completes
- idx_addr  out  32+PROC_BITS  index memory address
- idx_validin  out  1  index read strobe (one-cycle pulse)
- rowidx_in  in  32  index read data
- rowidx_valid_in  in  1  index read data valid
- data_addra, data_addrb  out  32+PROC_BITS  edge memory addresses, ports A and B
- data_validina, data_validinb  out  1  edge read strobes (one-cycle pulses)
- data_ina, data_inb  in  32  edge read data
- data_valid_ina, data_valid_inb  in  1  edge read data valid

Behaviour:
- Reset and clocking: one clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset values:
  - State is IDLE; FIFO is empty.
  - req_ready=1 the cycle after reset deasserts.
  - nbr_valid, nbr_last, done_out, idx_validin, data_validina and data_validinb are all 0.
  - All addresses are 0; the in-flight counter is 0.
- Reset mid-operation: aborts immediately. Responses arriving after reset are ignored until the next request.
- Address format:
  - Upper PROC_BITS = PROC_ID.
  - Lower 32 bits = the word index.
- State machine:
  - IDLE: on accept, latch v=req_vertex and go to P0_REQ.
  - P0_REQ: drive idx_addr=v and idx_validin=1 for one cycle, then go to P0_WAIT.
  - P0_WAIT: on rowidx_valid_in, latch start=rowidx_in and go to P1_REQ.
  - P1_REQ: drive idx_addr=v+1 (32-bit wrap) and pulse idx_validin, then go to P1_WAIT.
  - P1_WAIT: on rowidx_valid_in, latch end=rowidx_in and set cur=start.
    - If end<=start (zero degree, or a descending pointer treated as zero degree), go to FIN.
    - Otherwise go to STREAM.
  - STREAM: issue edge reads, then go to DRAIN when cur==end.
  - DRAIN: wait until inflight==0, FIFO empty, and the last beat is accepted, then go to FIN.
  - FIN: done_out=1 for one cycle, then go to IDLE.
- Edge read issue (STREAM):
  - Per cycle, issue up to two reads: port A at cur and port B at cur+1.
  - B is issued only if cur+1<end.
  - cur advances by the number issued.
  - Issue is permitted only if inflight + fifo_count + 2 <= OUT_DEPTH. This credit rule means the FIFO never overflows regardless of memory latency.
  - inflight increments per strobe and decrements per data_valid_in*.
- Response ordering:
  - Both ports have equal fixed latency, so responses return in issue order.
  - If data_valid_ina and data_valid_inb arrive in the same cycle, enqueue A then B (dual-enqueue FIFO).
  - An A-only response enqueues A.
  - A B-only response is legal only if its matching A was absent; enqueue B.
- Last-beat tagging: each FIFO entry carries a last bit, set when the entry's address == end-1.
- Output handshake: dequeue on nbr_valid && nbr_ready; simultaneous enqueue and dequeue is allowed.
- Zero-degree vertex: no data strobes are issued, no beats are emitted, and done_out still pulses.
- req_ready is 0 in every state except IDLE. A req_valid outside IDLE is ignored and not queued.
- Latency: first nbr_valid appears at the earliest 2+2·L_idx+L_data+1 cycles after accept, where L is the memory response latency.

Test Plan:
1. Basic expansion:
   - Setup: rowidx[5]=10, rowidx[6]=13, data[10..12]=7,9,2; request v=5 with nbr_ready=1.
   - Required: beats 7,9,2 in order; nbr_last only on 2; done_out pulses once; req_ready returns to 1.
2. Zero degree:
   - Setup: rowidx[3]=rowidx[4]=4; request v=3.
   - Required: no data_validin* pulses; no nbr_valid; done_out pulses once.
3. Backpressure:
   - Setup: rowidx[0]=0, rowidx[1]=20, data[i]=100+i; nbr_ready=0 for the first 30 cycles, then 1.
   - Required: exactly 20 beats 100..119; FIFO count never exceeds OUT_DEPTH; inflight never goes negative.
4. Odd-length dual-port issue:
   - Setup: degree 5 (start=40, end=45).
   - Required: port A reads 40,42,44 and port B reads 41,43 only; output ascending.
5. Busy request and reset mid-stream:
   - Pulse req_valid during STREAM: it is ignored, with req_ready=0.
   - Assert rst_in during STREAM: the next cycle has all outputs at reset values. A fresh request for v=5 then reproduces scenario 1 exactly.
6. Address tagging:
   - Setup: PROC_ID=3, PROC_BITS=4.
   - Required: every idx_addr/data_addr* has bits [35:32]=4'h3.

Source files
------------

// File: rtl/csr_neighbor_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : csr_neighbor_fetcher
// Purpose  : Expands one vertex of a CSR graph. Reads rowidx[v] and
//            rowidx[v+1] from the index memory, then fetches every edge entry
//            in [start, end) over two data read ports (A takes even offsets,
//            B the next one). Neighbour ids stream out in ascending address
//            order through a small dual-enqueue FIFO.
// Ports    : clk_in/rst_in          clock, synchronous active-high reset
//            req_*                  vertex request (accepted only in IDLE)
//            nbr_*                  neighbour stream (valid/ready, last tag)
//            done_out               one-cycle pulse at end of an expansion
//            idx_*/rowidx_*         index memory request/response
//            data_*a / data_*b      edge memory ports A and B
// Revision : 1.0  initial release
// ============================================================================
module csr_neighbor_fetcher #(
  parameter int PROC_BITS = 4,
  parameter int PROC_ID   = 0,
  parameter int OUT_DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [31:0]            req_vertex,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic [31:0]            nbr_out,
  output logic                   nbr_valid,
  input  logic                   nbr_ready,
  output logic                   nbr_last,
  output logic                   done_out,
  output logic [32+PROC_BITS-1:0] idx_addr,
  output logic                   idx_validin,
  input  logic [31:0]            rowidx_in,
  input  logic                   rowidx_valid_in,
  output logic [32+PROC_BITS-1:0] data_addra,
  output logic [32+PROC_BITS-1:0] data_addrb,
  output logic                   data_validina,
  output logic                   data_validinb,
  input  logic [31:0]            data_ina,
  input  logic [31:0]            data_inb,
  input  logic                   data_valid_ina,
  input  logic                   data_valid_inb
);

  localparam int c_AW = $clog2(OUT_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [PROC_BITS-1:0] c_PROC  = PROC_BITS'(PROC_ID);
  localparam logic [c_CW:0]        c_DEPTH = (c_CW+1)'(OUT_DEPTH);
  localparam logic [c_CW:0]        c_TWO   = (c_CW+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_P0_REQ  = 3'd1,
    S_P0_WAIT = 3'd2,
    S_P1_REQ  = 3'd3,
    S_P1_WAIT = 3'd4,
    S_STREAM  = 3'd5,
    S_DRAIN   = 3'd6,
    S_FIN     = 3'd7
  } state_t;

  state_t            r_state;
  logic [31:0]       r_vertex;
  logic [31:0]       r_start;
  logic [31:0]       r_end;
  logic [31:0]       r_cur;
  logic [31:0]       r_resp_addr;   // word index of the next response to land
  logic [c_CW-1:0]   r_inflight;
  logic [c_CW-1:0]   r_count;
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [32:0]       r_mem [OUT_DEPTH];   // {last, neighbour id}

  logic [31:0]       w_cur_p1;
  logic              w_credit_ok;
  logic              w_issue_a;
  logic              w_issue_b;
  logic              w_resp_ok;
  logic              w_enq_a;
  logic              w_enq_b;
  logic              w_deq;
  logic              w_last_a;
  logic              w_last_b;
  logic [c_AW-1:0]   w_wptr_b;

  assign w_cur_p1 = r_cur + 32'd1;

  // Credit counts reads already issued but not returned as well as entries
  // sitting in the FIFO, so every returning beat is guaranteed a slot.
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_count} + c_TWO) <= c_DEPTH;
  assign w_issue_a   = (r_state == S_STREAM) && (r_cur != r_end) && w_credit_ok;
  assign w_issue_b   = w_issue_a && (w_cur_p1 < r_end);

  // Responses outside an active fetch (e.g. stragglers after a reset) are dropped.
  assign w_resp_ok = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_enq_a   = w_resp_ok && data_valid_ina;
  assign w_enq_b   = w_resp_ok && data_valid_inb;
  assign w_deq     = nbr_valid && nbr_ready;

  // Responses return in issue order, so the address of each beat is implied.
  assign w_last_a = (r_resp_addr == (r_end - 32'd1));
  assign w_last_b = ((r_resp_addr + 32'(w_enq_a)) == (r_end - 32'd1));
  assign w_wptr_b = r_wptr + c_AW'(w_enq_a);

  assign req_ready = (r_state == S_IDLE);
  assign nbr_valid = (r_count != '0);
  assign nbr_out   = r_mem[r_rptr][31:0];
  assign nbr_last  = nbr_valid && r_mem[r_rptr][32];

  always_ff @(posedge clk_in) begin
    if (w_enq_a) r_mem[r_wptr]   <= {w_last_a, data_ina};
    if (w_enq_b) r_mem[w_wptr_b] <= {w_last_b, data_inb};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_vertex      <= '0;
      r_start       <= '0;
      r_end         <= '0;
      r_cur         <= '0;
      r_resp_addr   <= '0;
      r_inflight    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      done_out      <= 1'b0;
      idx_addr      <= '0;
      idx_validin   <= 1'b0;
      data_addra    <= '0;
      data_addrb    <= '0;
      data_validina <= 1'b0;
      data_validinb <= 1'b0;
    end else begin
      idx_validin   <= 1'b0;
      data_validina <= 1'b0;
      data_validinb <= 1'b0;
      done_out      <= 1'b0;

      r_inflight  <= r_inflight + c_CW'(w_issue_a) + c_CW'(w_issue_b)
                     - c_CW'(w_enq_a) - c_CW'(w_enq_b);
      r_count     <= r_count + c_CW'(w_enq_a) + c_CW'(w_enq_b) - c_CW'(w_deq);
      r_wptr      <= r_wptr + c_AW'(w_enq_a) + c_AW'(w_enq_b);
      r_rptr      <= r_rptr + c_AW'(w_deq);
      r_resp_addr <= r_resp_addr + 32'(w_enq_a) + 32'(w_enq_b);

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_vertex    <= req_vertex;
            idx_addr    <= {c_PROC, req_vertex};
            idx_validin <= 1'b1;
            r_state     <= S_P0_REQ;
          end
        end
        S_P0_REQ: r_state <= S_P0_WAIT;
        S_P0_WAIT: begin
          if (rowidx_valid_in) begin
            r_start     <= rowidx_in;
            idx_addr    <= {c_PROC, r_vertex + 32'd1};
            idx_validin <= 1'b1;
            r_state     <= S_P1_REQ;
          end
        end
        S_P1_REQ: r_state <= S_P1_WAIT;
        S_P1_WAIT: begin
          if (rowidx_valid_in) begin
            r_end       <= rowidx_in;
            r_cur       <= r_start;
            r_resp_addr <= r_start;
            // A descending pointer pair is handled as an empty row.
            if (rowidx_in <= r_start) begin
              done_out <= 1'b1;
              r_state  <= S_FIN;
            end else begin
              r_state  <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (r_cur == r_end) begin
            r_state <= S_DRAIN;
          end else begin
            if (w_issue_a) begin
              data_addra    <= {c_PROC, r_cur};
              data_validina <= 1'b1;
            end
            if (w_issue_b) begin
              data_addrb    <= {c_PROC, w_cur_p1};
              data_validinb <= 1'b1;
            end
            r_cur <= r_cur + 32'(w_issue_a) + 32'(w_issue_b);
          end
        end
        S_DRAIN: begin
          if ((r_inflight == '0) && (r_count == '0)) begin
            done_out <= 1'b1;
            r_state  <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_neighbor_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_neighbor_fetcher
// Purpose  : Directed bench for csr_neighbor_fetcher with a two-cycle
//            latency memory model for the index and both edge ports.
// Revision : 1.0  initial release
// ============================================================================
module tb_csr_neighbor_fetcher;

  localparam int PB    = 4;
  localparam int PID   = 3;
  localparam int DEPTH = 8;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic [31:0]     req_vertex = '0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [31:0]     nbr_out;
  logic            nbr_valid;
  logic            nbr_ready = 1'b0;
  logic            nbr_last;
  logic            done_out;
  logic [32+PB-1:0] idx_addr;
  logic            idx_validin;
  logic [31:0]     rowidx_in = '0;
  logic            rowidx_valid_in = 1'b0;
  logic [32+PB-1:0] data_addra;
  logic [32+PB-1:0] data_addrb;
  logic            data_validina;
  logic            data_validinb;
  logic [31:0]     data_ina = '0;
  logic [31:0]     data_inb = '0;
  logic            data_valid_ina = 1'b0;
  logic            data_valid_inb = 1'b0;

  csr_neighbor_fetcher #(.PROC_BITS(PB), .PROC_ID(PID), .OUT_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_vertex(req_vertex), .req_valid(req_valid), .req_ready(req_ready),
    .nbr_out(nbr_out), .nbr_valid(nbr_valid), .nbr_ready(nbr_ready),
    .nbr_last(nbr_last), .done_out(done_out),
    .idx_addr(idx_addr), .idx_validin(idx_validin),
    .rowidx_in(rowidx_in), .rowidx_valid_in(rowidx_valid_in),
    .data_addra(data_addra), .data_addrb(data_addrb),
    .data_validina(data_validina), .data_validinb(data_validinb),
    .data_ina(data_ina), .data_inb(data_inb),
    .data_valid_ina(data_valid_ina), .data_valid_inb(data_valid_inb)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  logic [31:0] idx_mem  [64];
  logic [31:0] data_mem [64];

  // Observations collected by the monitor
  logic [31:0] beat_v[$];
  logic        beat_l[$];
  logic [31:0] idx_q[$];
  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  int done_cnt, bad_tag, over_cnt, neg_cnt;

  // Expectations for the current expansion
  logic [31:0] exp_q[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  function automatic void clear_mon();
    beat_v.delete(); beat_l.delete(); idx_q.delete(); a_q.delete(); b_q.delete();
    done_cnt = 0; bad_tag = 0; over_cnt = 0; neg_cnt = 0;
  endfunction

  // Memory model and monitor, evaluated on the falling edge
  logic       ipv[2], apv[2], bpv[2];
  logic [5:0] ipa[2], apa[2], bpa[2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      ipv[i] = 0; apv[i] = 0; bpv[i] = 0; ipa[i] = 0; apa[i] = 0; bpa[i] = 0;
    end
    forever begin
      @(negedge clk_in);
      if (idx_validin) begin
        idx_q.push_back(idx_addr[31:0]);
        if (idx_addr[35:32] != 4'(PID)) bad_tag++;
      end
      if (data_validina) begin
        a_q.push_back(data_addra[31:0]);
        if (data_addra[35:32] != 4'(PID)) bad_tag++;
      end
      if (data_validinb) begin
        b_q.push_back(data_addrb[31:0]);
        if (data_addrb[35:32] != 4'(PID)) bad_tag++;
      end
      if (nbr_valid && nbr_ready) begin
        beat_v.push_back(nbr_out);
        beat_l.push_back(nbr_last);
      end
      if (done_out) done_cnt++;
      if (dut.r_count > 4'(DEPTH)) over_cnt++;
      if (dut.r_inflight > 4'(DEPTH)) neg_cnt++;
      ipv[1] = ipv[0]; ipa[1] = ipa[0]; ipv[0] = idx_validin;   ipa[0] = idx_addr[5:0];
      apv[1] = apv[0]; apa[1] = apa[0]; apv[0] = data_validina; apa[0] = data_addra[5:0];
      bpv[1] = bpv[0]; bpa[1] = bpa[0]; bpv[0] = data_validinb; bpa[0] = data_addrb[5:0];
      rowidx_valid_in = ipv[1]; rowidx_in = idx_mem[ipa[1]];
      data_valid_ina  = apv[1]; data_ina  = data_mem[apa[1]];
      data_valid_inb  = bpv[1]; data_inb  = data_mem[bpa[1]];
    end
  end

  task automatic expand(input logic [31:0] v, input int hold);
    int cyc;
    clear_mon();
    check_eq("req_ready_idle", 64'(req_ready), 1);
    req_vertex = v; req_valid = 1'b1; nbr_ready = (hold == 0);
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      nbr_ready = (cyc >= hold);
      @(posedge clk_in); #1;
      cyc++;
    end
    check_eq("req_ready_after_done", 64'(req_ready), 1);
    nbr_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("done_pulses", 64'(done_cnt), 1);
    check_eq("addr_tag_errors", 64'(bad_tag), 0);
  endtask

  task automatic check_result(input string name);
    check_eq({name, "_beat_count"}, 64'(beat_v.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < beat_v.size()) begin
        check_eq($sformatf("%s_beat%0d", name, i), 64'(beat_v[i]), 64'(exp_q[i]));
        check_eq($sformatf("%s_last%0d", name, i), 64'(beat_l[i]),
                 64'(i == exp_q.size() - 1));
      end
    end
    check_eq({name, "_porta_count"}, 64'(a_q.size()), 64'(exp_a.size()));
    foreach (exp_a[i]) if (i < a_q.size())
      check_eq($sformatf("%s_porta%0d", name, i), 64'(a_q[i]), 64'(exp_a[i]));
    check_eq({name, "_portb_count"}, 64'(b_q.size()), 64'(exp_b.size()));
    foreach (exp_b[i]) if (i < b_q.size())
      check_eq($sformatf("%s_portb%0d", name, i), 64'(b_q[i]), 64'(exp_b[i]));
  endtask

  task automatic set_basic_data();
    data_mem[10] = 32'd7; data_mem[11] = 32'd9; data_mem[12] = 32'd2;
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) begin idx_mem[i] = '0; data_mem[i] = '0; end
    idx_mem[5] = 10; idx_mem[6] = 13;
    idx_mem[3] = 4;  idx_mem[4] = 4;
    idx_mem[0] = 0;  idx_mem[1] = 20;
    idx_mem[7] = 40; idx_mem[8] = 45;
    for (int i = 40; i < 45; i++) data_mem[i] = 32'(300 + i);
    set_basic_data();
    clear_mon();

    // Reset values
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(posedge clk_in); #1;
    check_eq("rst_req_ready", 64'(req_ready), 1);
    check_eq("rst_nbr_valid", 64'(nbr_valid), 0);
    check_eq("rst_nbr_last", 64'(nbr_last), 0);
    check_eq("rst_done", 64'(done_out), 0);
    check_eq("rst_idx_validin", 64'(idx_validin), 0);
    check_eq("rst_validina", 64'(data_validina), 0);
    check_eq("rst_validinb", 64'(data_validinb), 0);
    check_eq("rst_idx_addr", 64'(idx_addr), 0);
    check_eq("rst_addra", 64'(data_addra), 0);
    check_eq("rst_addrb", 64'(data_addrb), 0);

    // Basic expansion: v=5 -> data[10..12]
    exp_q = '{32'd7, 32'd9, 32'd2}; exp_a = '{32'd10, 32'd12}; exp_b = '{32'd11};
    expand(32'd5, 0);
    check_result("basic");
    check_eq("basic_idx_count", 64'(idx_q.size()), 2);
    if (idx_q.size() == 2) begin
      check_eq("basic_idx0", 64'(idx_q[0]), 5);
      check_eq("basic_idx1", 64'(idx_q[1]), 6);
    end

    // Zero degree: v=3
    exp_q.delete(); exp_a.delete(); exp_b.delete();
    expand(32'd3, 0);
    check_result("zero");

    // Odd length: v=7 -> 40..44
    exp_q = '{32'd340, 32'd341, 32'd342, 32'd343, 32'd344};
    exp_a = '{32'd40, 32'd42, 32'd44}; exp_b = '{32'd41, 32'd43};
    expand(32'd7, 0);
    check_result("odd");

    // Backpressure: v=0 -> 100..119, consumer stalled for 30 cycles
    for (int i = 0; i < 20; i++) data_mem[i] = 32'(100 + i);
    exp_q.delete(); exp_a.delete(); exp_b.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(32'(100 + i));
    for (int i = 0; i < 20; i += 2) begin exp_a.push_back(32'(i)); exp_b.push_back(32'(i + 1)); end
    expand(32'd0, 30);
    check_result("bp");
    check_eq("bp_fifo_overflow", 64'(over_cnt), 0);
    check_eq("bp_inflight_underflow", 64'(neg_cnt), 0);

    // Busy request and reset mid-stream
    clear_mon();
    nbr_ready = 1'b0;
    req_vertex = 32'd0; req_valid = 1'b1;
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (a_q.size() == 0 && cyc < 100) begin @(posedge clk_in); #1; cyc++; end
    check_eq("busy_stream_reached", 64'(a_q.size() > 0), 1);
    repeat (4) @(posedge clk_in);
    #1;
    check_eq("busy_req_ready", 64'(req_ready), 0);
    req_vertex = 32'd5; req_valid = 1'b1;
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    check_eq("busy_ignored_idx_reads", 64'(idx_q.size()), 2);
    check_eq("busy_nbr_valid", 64'(nbr_valid), 1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check_eq("midrst_req_ready", 64'(req_ready), 1);
    check_eq("midrst_nbr_valid", 64'(nbr_valid), 0);
    check_eq("midrst_nbr_last", 64'(nbr_last), 0);
    check_eq("midrst_done", 64'(done_out), 0);
    check_eq("midrst_validina", 64'(data_validina), 0);
    check_eq("midrst_validinb", 64'(data_validinb), 0);
    check_eq("midrst_addra", 64'(data_addra), 0);
    check_eq("midrst_inflight", 64'(dut.r_inflight), 0);
    rst_in = 1'b0;
    repeat (6) @(posedge clk_in);
    #1;
    set_basic_data();
    exp_q = '{32'd7, 32'd9, 32'd2}; exp_a = '{32'd10, 32'd12}; exp_b = '{32'd11};
    expand(32'd5, 0);
    check_result("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
